// File: rtl/lstm_step_sched.sv
// LSTM time-step scheduler: shares one gate MAC and one activation unit across gates i,f,g,o,
// then updates C and h internally. Define LSTM_SCHED_SAT_EN for saturating arithmetic (default wraps).
module lstm_step_sched #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_W-1:0]        seq_len,
  input  logic signed [WIDTH-1:0] h_init,
  input  logic signed [WIDTH-1:0] c_init,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic                    mac_req,
  output logic [1:0]              mac_gate,
  output logic signed [WIDTH-1:0] mac_x,
  output logic signed [WIDTH-1:0] mac_h,
  input  logic                    mac_ack,
  input  logic signed [WIDTH-1:0] mac_result,
  output logic                    act_req,
  output logic                    act_tanh,
  output logic signed [WIDTH-1:0] act_in,
  input  logic                    act_ack,
  input  logic signed [WIDTH-1:0] act_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    y_last,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic signed [WIDTH-1:0] h_out,
  output logic signed [WIDTH-1:0] c_out,
  output logic                    busy
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_CELL, S_TANH, S_OUT} state_t;

`ifdef LSTM_SCHED_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_val(input logic neg);
    sat_val = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  function automatic logic signed [WIDTH-1:0] fxmul(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] prod;
    prod = a * b;
    prod = prod >>> FRAC;
`ifdef LSTM_SCHED_SAT_EN
    // Representable only when every bit above the result sign bit matches it.
    if (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}}) begin
      fxmul = sat_val(prod[2*WIDTH-1]);
    end else begin
      fxmul = prod[WIDTH-1:0];
    end
`else
    fxmul = prod[WIDTH-1:0];
`endif
  endfunction

  function automatic logic signed [WIDTH-1:0] cell_add(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] sum;
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
`ifdef LSTM_SCHED_SAT_EN
    if (sum[WIDTH] != sum[WIDTH-1]) begin
      cell_add = sat_val(sum[WIDTH]);
    end else begin
      cell_add = sum[WIDTH-1:0];
    end
`else
    cell_add = sum[WIDTH-1:0];
`endif
  endfunction

  state_t                  state_q;
  logic signed [WIDTH-1:0] x_q, h_q, c_q, pre_q;
  logic signed [WIDTH-1:0] gi_q, gf_q, gg_q, go_q;
  logic [1:0]              gate_q;
  logic [LEN_W-1:0]        step_q, len_q;
  logic                    x_ready_q, mac_req_q, act_req_q, act_tanh_q;
  logic                    y_valid_q, y_last_q, busy_q;
  logic signed [WIDTH-1:0] act_in_q;

  logic signed [WIDTH-1:0] c_d, h_d;
  logic [LEN_W-1:0]        len_d;
  logic                    last_d;

  // Datapath next values: cell update, hidden update, clamped length and last-step flag.
  always_comb begin
    c_d    = cell_add(fxmul(gf_q, c_q), fxmul(gi_q, gg_q));
    h_d    = fxmul(go_q, act_out);
    len_d  = (seq_len == {LEN_W{1'b0}}) ? {{(LEN_W-1){1'b0}}, 1'b1} : seq_len;
    last_d = (step_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));
  end

  // Scheduler FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= {WIDTH{1'b0}};
      h_q        <= {WIDTH{1'b0}};
      c_q        <= {WIDTH{1'b0}};
      pre_q      <= {WIDTH{1'b0}};
      gi_q       <= {WIDTH{1'b0}};
      gf_q       <= {WIDTH{1'b0}};
      gg_q       <= {WIDTH{1'b0}};
      go_q       <= {WIDTH{1'b0}};
      gate_q     <= 2'd0;
      step_q     <= {LEN_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      x_ready_q  <= 1'b1;
      mac_req_q  <= 1'b0;
      act_req_q  <= 1'b0;
      act_tanh_q <= 1'b0;
      act_in_q   <= {WIDTH{1'b0}};
      y_valid_q  <= 1'b0;
      y_last_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (x_valid) begin
            x_q       <= x_in;
            gate_q    <= 2'd0;
            if (step_q == {LEN_W{1'b0}}) begin
              h_q   <= h_init;
              c_q   <= c_init;
              len_q <= len_d;
            end
            state_q   <= S_MAC;
            x_ready_q <= 1'b0;
            mac_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_MAC: begin
          if (mac_ack) begin
            pre_q      <= mac_result;
            state_q    <= S_ACT;
            mac_req_q  <= 1'b0;
            act_req_q  <= 1'b1;
            act_tanh_q <= (gate_q == 2'd2);
            act_in_q   <= mac_result;
          end
        end
        S_ACT: begin
          if (act_ack) begin
            case (gate_q)
              2'd0:    gi_q <= act_out;
              2'd1:    gf_q <= act_out;
              2'd2:    gg_q <= act_out;
              default: go_q <= act_out;
            endcase
            act_req_q <= 1'b0;
            if (gate_q == 2'd3) begin
              state_q <= S_CELL;
            end else begin
              gate_q    <= gate_q + 2'd1;
              state_q   <= S_MAC;
              mac_req_q <= 1'b1;
            end
          end
        end
        S_CELL: begin
          // The tanh operand is the freshly computed C, so forward it directly.
          c_q        <= c_d;
          state_q    <= S_TANH;
          act_req_q  <= 1'b1;
          act_tanh_q <= 1'b1;
          act_in_q   <= c_d;
        end
        S_TANH: begin
          if (act_ack) begin
            h_q        <= h_d;
            state_q    <= S_OUT;
            act_req_q  <= 1'b0;
            act_tanh_q <= 1'b0;
            y_valid_q  <= 1'b1;
            y_last_q   <= last_d;
          end
        end
        S_OUT: begin
          if (y_ready) begin
            step_q    <= y_last_q ? {LEN_W{1'b0}} : (step_q + {{(LEN_W-1){1'b0}}, 1'b1});
            state_q   <= S_IDLE;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          x_ready_q  <= 1'b1;
          mac_req_q  <= 1'b0;
          act_req_q  <= 1'b0;
          act_tanh_q <= 1'b0;
          y_valid_q  <= 1'b0;
          y_last_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign x_ready  = x_ready_q;
  assign mac_req  = mac_req_q;
  assign mac_gate = gate_q;
  assign mac_x    = x_q;
  assign mac_h    = h_q;
  assign act_req  = act_req_q;
  assign act_tanh = act_tanh_q;
  assign act_in   = act_in_q;
  assign y_out    = h_q;
  assign y_last   = y_last_q;
  assign y_valid  = y_valid_q;
  assign h_out    = h_q;
  assign c_out    = c_q;
  assign busy     = busy_q;

endmodule
